// File: rtl/diff_decoder_stream.sv
// diff_decoder_stream: streaming M-PSK differential decoder.
// Each output symbol is the modulo-2^SYM_BITS phase step from the previous
// symbol in stream order. Lane 0 is differenced against the last lane of the
// previous accepted beat, or against REF_INIT when the beat starts a frame.
// Optional Gray mapping is applied around the subtraction. A single output
// register slice provides valid/ready flow control.
//
// Handshake: a beat transfers on any rising edge where valid && ready. The
// sender holds valid and data stable until that edge. s_ready depends
// combinationally on m_ready, so a stalled slice frees up as soon as the
// sink becomes ready.
module diff_decoder_stream #(
  parameter int SYM_BITS  = 2,
  parameter int LANES     = 2,
  parameter int FRAME_LEN = 4,
  parameter int REF_INIT  = 0,
  parameter int GRAY      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*SYM_BITS-1:0] s_data,
  input  logic                      resync,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*SYM_BITS-1:0] m_data,
  output logic                      m_first
);

  localparam int W     = LANES * SYM_BITS;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_RESYNC = CNT_W'((FRAME_LEN == 1) ? 0 : 1);
  localparam logic [SYM_BITS-1:0] REF_RST = SYM_BITS'(REF_INIT);

  function automatic logic [SYM_BITS-1:0] gray2bin(input logic [SYM_BITS-1:0] g);
    logic [SYM_BITS-1:0] b;
    b[SYM_BITS-1] = g[SYM_BITS-1];
    for (int k = SYM_BITS - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  function automatic logic [SYM_BITS-1:0] bin2gray(input logic [SYM_BITS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [SYM_BITS-1:0] ref_q, ref_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fresh_q, fresh_d;
  logic                m_valid_q, m_valid_d;
  logic [W-1:0]        m_data_q, m_data_d;
  logic                m_first_q, m_first_d;

  logic                accept;
  logic                frame_start;
  logic [W-1:0]        dec_data;
  logic [SYM_BITS-1:0] sym_v, nat_v, diff_v, prev_v;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // A beat starts a frame after reset, on counter wrap, or on resync.
  assign frame_start = fresh_q || resync || ((FRAME_LEN != 0) && (cnt_q == '0));

  // Per-lane differencing chain; prev_v ends holding the newest natural symbol.
  always_comb begin
    dec_data = '0;
    prev_v   = frame_start ? REF_RST : ref_q;
    sym_v    = '0;
    nat_v    = '0;
    diff_v   = '0;
    for (int i = 0; i < LANES; i++) begin
      sym_v  = s_data[SYM_BITS*i +: SYM_BITS];
      nat_v  = (GRAY != 0) ? gray2bin(sym_v) : sym_v;
      diff_v = nat_v - prev_v;
      dec_data[SYM_BITS*i +: SYM_BITS] = (GRAY != 0) ? bin2gray(diff_v) : diff_v;
      prev_v = nat_v;
    end
  end

  // Reference and frame bookkeeping advance only on an accepted beat.
  always_comb begin
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    fresh_d = fresh_q;
    if (accept) begin
      ref_d   = prev_v;
      fresh_d = 1'b0;
      if (FRAME_LEN != 0) begin
        if (resync)                 cnt_d = CNT_RESYNC;
        else if (cnt_q == CNT_LAST) cnt_d = '0;
        else                        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output slice: load on accept, drain when the sink takes the beat.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_first_d = m_first_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = dec_data;
      m_first_d = frame_start;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q   <= REF_RST;
      cnt_q   <= '0;
      fresh_q <= 1'b1;
    end else begin
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
    end
  end

  // Output slice registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_first_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_first_q <= m_first_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_first = m_first_q;

endmodule

// File: tb/tb_diff_decoder_stream.sv
// Bench for diff_decoder_stream: two instances (plain QPSK x2 lanes with
// framing; Gray QPSK x1 lane without framing) share control inputs.
module tb_diff_decoder_stream;

  localparam int SB_A = 2, LN_A = 2, FL_A = 4, RI_A = 0, GR_A = 0;
  localparam int SB_B = 2, LN_B = 1, FL_B = 0, RI_B = 0, GR_B = 1;
  localparam int WA = SB_A * LN_A;
  localparam int WB = SB_B * LN_B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_valid, m_ready, resync;
  logic [WA-1:0] s_data_a, m_data_a;
  logic [WB-1:0] s_data_b, m_data_b;
  logic s_ready_a, m_valid_a, m_first_a;
  logic s_ready_b, m_valid_b, m_first_b;

  diff_decoder_stream #(.SYM_BITS(SB_A), .LANES(LN_A), .FRAME_LEN(FL_A),
                        .REF_INIT(RI_A), .GRAY(GR_A)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_data(s_data_a), .resync(resync), .m_valid(m_valid_a),
    .m_ready(m_ready), .m_data(m_data_a), .m_first(m_first_a));

  diff_decoder_stream #(.SYM_BITS(SB_B), .LANES(LN_B), .FRAME_LEN(FL_B),
                        .REF_INIT(RI_B), .GRAY(GR_B)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data_b), .resync(resync), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_data(m_data_b), .m_first(m_first_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nat_of(input int s, input int sb, input int gray);
    int b;
    b = s;
    if (gray != 0) for (int k = 1; k < sb; k++) b = b ^ (s >> k);
    return b;
  endfunction

  function automatic int enc_of(input int d, input int gray);
    return (gray != 0) ? (d ^ (d >> 1)) : d;
  endfunction

  // Phase differences of one beat given the phase before lane 0.
  function automatic int model_beat(input int data, input int sb, input int lanes,
                                    input int gray, input int prev_in, output int prev_out);
    int mask, res, prev, n, d;
    mask = (1 << sb) - 1;
    res  = 0;
    prev = prev_in;
    for (int i = 0; i < lanes; i++) begin
      n    = nat_of((data >> (sb * i)) & mask, sb, gray);
      d    = (n - prev) & mask;
      res  = res | (enc_of(d, gray) << (sb * i));
      prev = n;
    end
    prev_out = prev;
    return res;
  endfunction

  // Model state: last natural phase, beats since frame start, fresh-after-reset.
  int prev_a = RI_A, pos_a = 0;
  int prev_b = RI_B, pos_b = 0;
  bit fresh_a = 1'b1, fresh_b = 1'b1;
  logic [WA:0] exp_a_q[$];
  logic [WB:0] exp_b_q[$];

  always @(posedge rst) begin
    exp_a_q.delete(); exp_b_q.delete();
    prev_a = RI_A; pos_a = 0; fresh_a = 1'b1;
    prev_b = RI_B; pos_b = 0; fresh_b = 1'b1;
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    bit acc, drn, st;
    int d, np;
    if (!rst) begin
      // instance A
      check("a_valid", m_valid_a, exp_a_q.size() != 0);
      check("a_ready", s_ready_a, (exp_a_q.size() == 0) || m_ready);
      if (exp_a_q.size() != 0) check("a_beat", {m_first_a, m_data_a}, exp_a_q[0]);
      drn = (exp_a_q.size() != 0) && m_ready;
      acc = s_valid && ((exp_a_q.size() == 0) || m_ready);
      if (drn) void'(exp_a_q.pop_front());
      if (acc) begin
        st = fresh_a || resync || ((FL_A > 0) && (pos_a == FL_A));
        d  = model_beat(int'(s_data_a), SB_A, LN_A, GR_A, st ? RI_A : prev_a, np);
        prev_a = np; pos_a = st ? 1 : pos_a + 1; fresh_a = 1'b0;
        exp_a_q.push_back({st, WA'(d)});
      end
      // instance B
      check("b_valid", m_valid_b, exp_b_q.size() != 0);
      check("b_ready", s_ready_b, (exp_b_q.size() == 0) || m_ready);
      if (exp_b_q.size() != 0) check("b_beat", {m_first_b, m_data_b}, exp_b_q[0]);
      drn = (exp_b_q.size() != 0) && m_ready;
      acc = s_valid && ((exp_b_q.size() == 0) || m_ready);
      if (drn) void'(exp_b_q.pop_front());
      if (acc) begin
        st = fresh_b || resync || ((FL_B > 0) && (pos_b == FL_B));
        d  = model_beat(int'(s_data_b), SB_B, LN_B, GR_B, st ? RI_B : prev_b, np);
        prev_b = np; pos_b = st ? 1 : pos_b + 1; fresh_b = 1'b0;
        exp_b_q.push_back({st, WB'(d)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic rs);
    s_valid = 1'b1; s_data_a = a; s_data_b = b; resync = rs;
    step();
    s_valid = 1'b0; resync = 1'b0;
  endtask

  logic [WA-1:0] tab_a [12] = '{4'h3, 4'h7, 4'hA, 4'h1, 4'hF, 4'h4,
                                4'h9, 4'h2, 4'hC, 4'h6, 4'hE, 4'h5};
  logic [11:0] rdy_pat = 12'b1011_0111_0110;

  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; resync = 1'b0;
    s_data_a = '0; s_data_b = '0;
    step(); step();
    check("rst_valid", m_valid_a, 1'b0);
    check("rst_data",  m_data_a, '0);
    check("rst_first", m_first_a, 1'b0);
    check("rst_ready", s_ready_a, 1'b1);
    rst = 1'b0;
    step();

    // Basic difference and Gray mapping
    send(4'b1101, 2'b11, 1'b0);
    check("basic0", {m_first_a, m_data_a}, 5'b1_1001);
    check("gray0",  {m_first_b, m_data_b}, 3'b1_11);
    send(4'b0000, 2'b10, 1'b0);
    check("basic1", {m_first_a, m_data_a}, 5'b0_0001);
    check("gray1",  {m_first_b, m_data_b}, 3'b0_01);

    // Resync on the third beat; frame then lasts four beats
    send(4'b1110, 2'b10, 1'b1);
    check("resync_a", {m_first_a, m_data_a}, 5'b1_0110);
    check("resync_b", {m_first_b, m_data_b}, 3'b1_10);
    send(4'b0000, 2'b00, 1'b0);
    check("frame_b1", {m_first_a, m_data_a}, 5'b0_0001);
    send(4'b0000, 2'b00, 1'b0);
    check("frame_b2", {m_first_a, m_data_a}, 5'b0_0000);
    send(4'b0000, 2'b00, 1'b0);
    check("frame_b3", {m_first_a, m_data_a}, 5'b0_0000);
    send(4'b0101, 2'b00, 1'b0);
    check("wrap_a", {m_first_a, m_data_a}, 5'b1_0001);
    check("nowrap_b", m_first_b, 1'b0);

    // Backpressure: output frozen, pending beat waits
    m_ready = 1'b0; s_valid = 1'b1; s_data_a = 4'b1011; s_data_b = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ready", s_ready_a, 1'b0);
      check("bp_hold", {m_first_a, m_data_a}, 5'b1_0001);
    end
    m_ready = 1'b1; #1;
    check("bp_release", s_ready_a, 1'b1);
    step();
    s_valid = 1'b0;
    check("bp_next", {m_first_a, m_data_a}, 5'b0_1110);

    // resync without an accept is not remembered
    resync = 1'b1; step(); resync = 1'b0;
    send(4'b0000, 2'b00, 1'b0);
    check("resync_idle", {m_first_a, m_data_a}, 5'b0_0010);

    // Mixed flow-control run
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data_a = tab_a[i]; s_data_b = tab_a[i][1:0];
      m_ready = rdy_pat[i]; resync = (i == 6);
      step();
    end
    s_valid = 1'b0; resync = 1'b0; m_ready = 1'b1;
    step(); step();

    // Asynchronous reset mid-stream
    send(4'b0110, 2'b11, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", m_valid_a, 1'b0);
    check("arst_data",  m_data_a, '0);
    check("arst_first", m_first_a, 1'b0);
    check("arst_valid_b", m_valid_b, 1'b0);
    @(negedge clk); #1 rst = 1'b0;
    step();
    send(4'b0110, 2'b11, 1'b0);
    check("post_rst_a", {m_first_a, m_data_a}, 5'b1_1110);
    check("post_rst_b", {m_first_b, m_data_b}, 3'b1_11);
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
